// File: rtl/game_result_monitor.sv
// Game result monitor: synchronizes the game chip's output pins, turns
// rising edges of result_valid into scored result events, keeps per-game
// shot/hit/streak statistics and captures the muxed field data into five
// readable field registers.
module game_result_monitor #(
    parameter int MAX_SHOTS = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] uo_in,
    input  logic [2:0] field_sel,
    input  logic       clear_stats,
    input  logic [2:0] rd_addr,
    output logic [4:0] rd_data,
    output logic       result_pulse,
    output logic       last_hit,
    output logic [7:0] shots,
    output logic [7:0] hits,
    output logic [3:0] streak,
    output logic [3:0] best_streak,
    output logic       game_over
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PLAYING = 2'd1;
    localparam logic [1:0] ST_OVER    = 2'd2;

    localparam logic [7:0] MAX_SHOTS_L = 8'(MAX_SHOTS);
    localparam int         NUM_FIELDS  = 5;

    // Synchronizer chain; s3 keeps the previous s2 for edge and stability detection.
    logic [6:0] s1_q, s2_q, s3_q;

    // Registered event so counters update three edges after the first sample.
    logic       evt_q, evt_d;
    logic       evt_hit_q, evt_hit_d;

    logic [1:0] state_q, state_d;
    logic [7:0] shots_q, shots_d;
    logic [7:0] hits_q, hits_d;
    logic [3:0] streak_q, streak_d;
    logic [3:0] best_q, best_d;
    logic       last_hit_q, last_hit_d;
    logic       pulse_q, pulse_d;

    logic       cap_en;
    logic [7:0] shots_inc;
    logic [7:0] hits_inc;
    logic [3:0] streak_inc;

    // Two-flop synchronizer plus history stage; bit 7 is not used by the game.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            s1_q <= uo_in[6:0];
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    // A new game request throws away an event that is still in the pipe.
    always_comb begin
        evt_d     = s2_q[0] & ~s3_q[0];
        evt_hit_d = s2_q[1];
        if (clear_stats) begin
            evt_d = 1'b0;
        end
    end

    // Event pipeline register.
    always_ff @(posedge clk) begin
        if (reset) begin
            evt_q     <= 1'b0;
            evt_hit_q <= 1'b0;
        end else begin
            evt_q     <= evt_d;
            evt_hit_q <= evt_hit_d;
        end
    end

    assign shots_inc  = (shots_q == 8'hFF) ? shots_q : shots_q + 8'd1;
    assign hits_inc   = (hits_q == 8'hFF) ? hits_q : hits_q + 8'd1;
    assign streak_inc = (streak_q == 4'hF) ? streak_q : streak_q + 4'd1;

    // Game state machine and statistics next-state; clear beats any event.
    always_comb begin
        state_d    = state_q;
        shots_d    = shots_q;
        hits_d     = hits_q;
        streak_d   = streak_q;
        best_d     = best_q;
        last_hit_d = last_hit_q;
        pulse_d    = 1'b0;
        case (state_q)
            ST_IDLE, ST_PLAYING: begin
                if (evt_q) begin
                    pulse_d    = 1'b1;
                    last_hit_d = evt_hit_q;
                    shots_d    = shots_inc;
                    state_d    = (shots_inc == MAX_SHOTS_L) ? ST_OVER : ST_PLAYING;
                    if (evt_hit_q) begin
                        hits_d   = hits_inc;
                        streak_d = streak_inc;
                        if (streak_inc > best_q) begin
                            best_d = streak_inc;
                        end
                    end else begin
                        streak_d = 4'd0;
                    end
                end
            end
            ST_OVER: begin
                state_d = ST_OVER;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (clear_stats) begin
            state_d    = ST_IDLE;
            shots_d    = 8'd0;
            hits_d     = 8'd0;
            streak_d   = 4'd0;
            best_d     = 4'd0;
            last_hit_d = 1'b0;
            pulse_d    = 1'b0;
        end
    end

    // Game state and statistics registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            shots_q    <= 8'd0;
            hits_q     <= 8'd0;
            streak_q   <= 4'd0;
            best_q     <= 4'd0;
            last_hit_q <= 1'b0;
            pulse_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            shots_q    <= shots_d;
            hits_q     <= hits_d;
            streak_q   <= streak_d;
            best_q     <= best_d;
            last_hit_q <= last_hit_d;
            pulse_q    <= pulse_d;
        end
    end

    // Field data is trusted only once it has been identical for two samples.
    assign cap_en = (s2_q[6:2] == s3_q[6:2]) && (field_sel <= 3'd4);

    for (genvar gi = 0; gi < NUM_FIELDS; gi++) begin : g_field
        logic [4:0] field_q;

        // One capture register per field, loaded while its field is shown.
        always_ff @(posedge clk) begin
            if (reset) begin
                field_q <= 5'd0;
            end else if (cap_en && (field_sel == 3'(gi))) begin
                field_q <= s2_q[6:2];
            end
        end
    end

    // Combinational field readback; unused addresses read as zero.
    always_comb begin
        rd_data = 5'd0;
        case (rd_addr)
            3'd0:    rd_data = g_field[0].field_q;
            3'd1:    rd_data = g_field[1].field_q;
            3'd2:    rd_data = g_field[2].field_q;
            3'd3:    rd_data = g_field[3].field_q;
            3'd4:    rd_data = g_field[4].field_q;
            default: rd_data = 5'd0;
        endcase
    end

    assign result_pulse = pulse_q;
    assign last_hit     = last_hit_q;
    assign shots        = shots_q;
    assign hits         = hits_q;
    assign streak       = streak_q;
    assign best_streak  = best_q;
    assign game_over    = (state_q == ST_OVER);

endmodule

// File: doc/game_result_monitor.md
GAME_RESULT_MONITOR -- requirements
Module: game_result_monitor

Interface
REQ-001 Parameter MAX_SHOTS, default 10: number of result events per game; legal range 1..255.
REQ-002 clk  input  1  single clock; all logic on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 uo_in  input  8  game chip output pins: [0] result_valid, [1] hit, [6:2] muxed field data, [7] unused. Pins are asynchronous to clk.
REQ-005 field_sel  input  3  field the game chip is currently showing: 0 cannon x, 1 aim, 2 target x, 3 target y, 4 trajectory position, 5..7 none.
REQ-006 clear_stats  input  1  one-cycle request to start a new game.
REQ-007 rd_addr  input  3  field readback address (same encoding as field_sel).
REQ-008 rd_data  output  5  captured field value at rd_addr; 0 for addresses 5..7.
REQ-009 result_pulse  output  1  one-cycle pulse per detected result event.
REQ-010 last_hit  output  1  hit flag of the most recent result event.
REQ-011 shots  output  8  result events this game.
REQ-012 hits  output  8  hit events this game.
REQ-013 streak  output  4  current consecutive-hit count.
REQ-014 best_streak  output  4  maximum streak this game.
REQ-015 game_over  output  1  high once shots reaches MAX_SHOTS.

Function
REQ-016 uo_in[6:0] SHALL pass through a two-flop synchronizer (s1, s2); a third register s3 holds the previous s2; uo_in[7] is ignored.
REQ-017 A result event SHALL be s2[0]=1 and s3[0]=0; a level held high counts once.
REQ-018 The event's hit value SHALL be s2[1] in the same cycle as the event.
REQ-019 If uo_in[0] is first sampled high at edge k, counters, last_hit and result_pulse SHALL update at edge k+3; result_pulse is high for exactly one cycle.
REQ-020 State machine states: IDLE, PLAYING, GAME_OVER.
REQ-021 IDLE: no event this game; first event -> PLAYING, or -> GAME_OVER if MAX_SHOTS=1.
REQ-022 PLAYING: each event increments shots; the event that makes shots equal MAX_SHOTS -> GAME_OVER.
REQ-023 GAME_OVER: game_over=1; events are ignored (no pulse, no counter change); clear_stats -> IDLE.
REQ-024 On an accepted hit: hits+1, streak+1; best_streak SHALL be max(best_streak, new streak) at the same edge.
REQ-025 On an accepted miss: streak cleared to 0; hits and best_streak unchanged.
REQ-026 hits, shots saturate at 255; streak, best_streak saturate at 15.
REQ-027 clear_stats in any state SHALL zero shots, hits, streak, best_streak, last_hit and game_over and enter IDLE; captured fields are retained.
REQ-028 clear_stats and an event in the same cycle: clear wins; the event is discarded and result_pulse stays 0.
REQ-029 Field capture: when s2[6:2] equals s3[6:2] (stable two cycles) and field_sel is 0..4, field register [field_sel] SHALL load s2[6:2]; unstable data or field_sel 5..7 writes nothing.
REQ-030 Field capture runs in all states, independent of result events.
REQ-031 rd_data SHALL be combinational from rd_addr and the field registers.

Reset
REQ-032 reset SHALL set all synchronizer flops, the five field registers and all counters to 0, last_hit=0, result_pulse=0, game_over=0, state IDLE.
REQ-033 reset dominates clear_stats and events in the same cycle; an event whose edge is in flight in the synchronizer when reset is applied SHALL be lost.

Verification
REQ-034 reset; uo_in[0] high for 5 cycles with uo_in[1]=1 -> one result_pulse, exactly 3 edges after the first sample; shots=1, hits=1, streak=1, best_streak=1, last_hit=1.
REQ-035 pattern hit,hit,hit,miss,hit -> shots=5, hits=4, streak=1, best_streak=3, last_hit=1.
REQ-036 MAX_SHOTS=10; 12 events -> game_over=1 after the 10th; shots=10; events 11 and 12 produce no pulse; clear_stats -> all counters 0, game_over=0.
REQ-037 field_sel=2, uo_in[6:2]=5'd19 held 3 cycles -> rd_addr=2 gives 19; field_sel=6 with data 5'd7 -> all fields unchanged; data toggling every cycle -> no write.
REQ-038 clear_stats coincident with an event edge -> counters 0, no result_pulse.
REQ-039 20 consecutive hits -> streak=15, best_streak=15, hits=20 (MAX_SHOTS=255).
